// File: rtl/axis_mm2s_feeder_pkg.sv
// Shared constants and FSM encoding for the memory-to-stream feeder.
package axis_mm2s_feeder_pkg;

    localparam int unsigned DEFAULT_BEAT_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/axis_mm2s_feeder_fifo2.sv
// Two-entry stream FIFO; head register drives the output so payload holds while stalled.
module axis_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Input ready depends only on occupancy, never on m_ready.
    assign s_ready = (count != 2'd2);
    assign m_valid = (count != 2'd0);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= s_data;
                    end else begin
                        tail <= s_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= s_data;
                    end else begin
                        head <= tail;
                        tail <= s_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/axis_mm2s_feeder.sv
// Reads a contiguous byte range from a 1-cycle-latency memory and emits it as an AXI-stream.
module axis_mm2s_feeder
    import axis_mm2s_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_BEAT_BYTES * 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_bytes,
    output logic                    mem_ren,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    done
);

    localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned OFFSET_BITS = $clog2(BEAT_BYTES);
    localparam int unsigned FIFO_WIDTH  = DATA_WIDTH + BEAT_BYTES + 1;

    state_t                  state;
    state_t                  state_next;
    logic                    ready_en;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    reads_left;
    logic [OFFSET_BITS-1:0]  tail_bytes;
    logic                    zero_done;
    logic                    rd_pending;
    logic                    rd_last;
    logic [BEAT_BYTES-1:0]   rd_keep;
    logic [LEN_WIDTH-1:0]    cmd_beats;
    logic [BEAT_BYTES-1:0]   last_keep;
    logic                    cmd_fire;
    logic                    issue;
    logic                    pop;
    logic                    room;
    logic [1:0]              occupancy;
    logic                    fifo_in_ready;
    logic [FIFO_WIDTH-1:0]   fifo_in;
    logic [FIFO_WIDTH-1:0]   fifo_out;

    assign cmd_beats = (cmd_bytes >> OFFSET_BITS)
                     + LEN_WIDTH'(|cmd_bytes[OFFSET_BITS-1:0]);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign mem_ren   = issue;
    assign mem_addr  = addr_q;

    // In-flight read plus buffered beats, reconstructed from the FIFO's two flags.
    assign occupancy = 2'(rd_pending) + 2'(m_axis_tvalid) + 2'(!fifo_in_ready);
    // A beat leaving this cycle frees its slot in time for the new read's data.
    assign room      = (occupancy < 2'd2) || (pop && (occupancy == 2'd2));

    always_comb begin
        last_keep = '0;
        for (int unsigned i = 0; i < BEAT_BYTES; i++) begin
            last_keep[i] = (tail_bytes == '0) || (OFFSET_BITS'(i) < tail_bytes);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ready_en;
                if (cmd_valid && ready_en) begin
                    state_next = (cmd_beats == '0) ? IDLE : READ;
                end
            end
            READ: begin
                issue = room;
                if (room && (reads_left == LEN_WIDTH'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign done = zero_done || ((state == DRAIN) && pop && m_axis_tlast);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en   <= 1'b0;
            addr_q     <= '0;
            reads_left <= '0;
            tail_bytes <= '0;
            zero_done  <= 1'b0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
            rd_keep    <= '0;
        end else begin
            ready_en   <= 1'b1;
            zero_done  <= cmd_fire && (cmd_beats == '0);
            // Sideband for the read just issued travels alongside its returning data.
            rd_pending <= issue;
            rd_last    <= issue && (reads_left == LEN_WIDTH'(1));
            rd_keep    <= (reads_left == LEN_WIDTH'(1)) ? last_keep : '1;
            if (cmd_fire) begin
                addr_q     <= cmd_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
                reads_left <= cmd_beats;
                tail_bytes <= cmd_bytes[OFFSET_BITS-1:0];
            end else if (issue) begin
                addr_q     <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
                reads_left <= reads_left - LEN_WIDTH'(1);
            end
        end
    end

    assign fifo_in = {mem_rdata, rd_keep, rd_last};

    axis_fifo2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_valid (rd_pending),
        .s_ready (fifo_in_ready),
        .s_data  (fifo_in),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (fifo_out)
    );

    assign m_axis_tdata = fifo_out[FIFO_WIDTH-1 -: DATA_WIDTH];
    assign m_axis_tkeep = fifo_out[BEAT_BYTES:1];
    assign m_axis_tlast = fifo_out[0];

endmodule

// File: tb/tb_axis_mm2s_feeder.sv
// Scoreboard bench: commands queue expected reads/beats, a negedge monitor checks them.
module tb_axis_mm2s_feeder;

    logic         aclk;
    logic         aresetn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic [31:0]  cmd_bytes;
    logic         mem_ren;
    logic [31:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic         done;

    axis_mm2s_feeder #(
        .DATA_WIDTH (128),
        .ADDR_WIDTH (32),
        .LEN_WIDTH  (32)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_bytes     (cmd_bytes),
        .mem_ren       (mem_ren),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .done          (done)
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_addrs[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    int reads_issued = 0;
    int hs_cycle = 0;
    int first_tv_cycle = -1;
    int last_cycle = -1;
    bit arm_first = 0;

    logic         ren_s = 1'b0;
    logic [31:0]  addr_s = '0;
    bit           stall_prev = 0;
    logic [127:0] prev_data;
    logic [15:0]  prev_keep;
    logic         prev_last;
    beat_t        eb;
    logic [31:0]  ea;

    function automatic logic [127:0] memword(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h0101_0101, a};
    endfunction

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc = cyc + 1;

    // Memory: sample request at negedge, return data just after the following edge.
    always @(negedge aclk) begin
        ren_s  = mem_ren;
        addr_s = mem_addr;
    end
    always @(posedge aclk) begin
        #1;
        if (ren_s) mem_rdata = memword(addr_s);
        else       mem_rdata = {4{32'hBAD0_BAD0}};
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (stall_prev) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                    m_axis_tkeep !== prev_keep || m_axis_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b data=%h keep=%h last=%b, need valid=1 data=%h keep=%h last=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                             prev_data, prev_keep, prev_last);
                end
            end
            if (m_axis_tvalid && arm_first) begin
                first_tv_cycle = cyc;
                arm_first = 0;
            end
            if (mem_ren) begin
                reads_issued++;
                checks++;
                if (exp_addrs.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: got mem_addr=%h, need no read", mem_addr);
                end else begin
                    ea = exp_addrs.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL mem_addr: got %h, need %h", mem_addr, ea);
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                checks++;
                if (exp_beats.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h keep=%h last=%b, need no beat",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                end else begin
                    eb = exp_beats.pop_front();
                    if (m_axis_tdata !== eb.data || m_axis_tkeep !== eb.keep || m_axis_tlast !== eb.last) begin
                        errors++;
                        $display("FAIL beat: got data=%h keep=%h last=%b, need data=%h keep=%h last=%b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, eb.data, eb.keep, eb.last);
                    end
                    checks++;
                    if (done !== eb.last) begin
                        errors++;
                        $display("FAIL done_on_last: got done=%b, need %b", done, eb.last);
                    end
                end
                if (m_axis_tlast) last_cycle = cyc;
            end
            if (mem_ren) begin
                checks++;
                if (reads_issued - beats_seen > 2) begin
                    errors++;
                    $display("FAIL occupancy: got %0d reads+beats, need <= 2", reads_issued - beats_seen);
                end
            end
            if (done) done_cnt++;
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_keep  = m_axis_tkeep;
            prev_last  = m_axis_tlast;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, got, need);
        end
    endtask

    task automatic reset_check();
        check_eq("rst_cmd_ready", 128'(cmd_ready), 128'(0));
        check_eq("rst_mem_ren",   128'(mem_ren), 128'(0));
        check_eq("rst_mem_addr",  128'(mem_addr), 128'(0));
        check_eq("rst_tvalid",    128'(m_axis_tvalid), 128'(0));
        check_eq("rst_tlast",     128'(m_axis_tlast), 128'(0));
        check_eq("rst_tkeep",     128'(m_axis_tkeep), 128'(0));
        check_eq("rst_done",      128'(done), 128'(0));
    endtask

    task automatic release_reset();
        @(negedge aclk);
        aresetn = 1'b1;
        #1 check_eq("ready_after_release", 128'(cmd_ready), 128'(0));
        @(negedge aclk);
        check_eq("ready_one_cycle_later", 128'(cmd_ready), 128'(1));
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] bytes);
        logic [31:0] base;
        logic [31:0] rem;
        int unsigned n;
        beat_t b;
        bit seen;
        base = addr & 32'hFFFF_FFF0;
        rem  = bytes % 32'd16;
        n    = bytes / 32'd16 + ((rem != 0) ? 1 : 0);
        for (int unsigned k = 0; k < n; k++) begin
            exp_addrs.push_back(base + 32'(k * 16));
            b.data = memword(base + 32'(k * 16));
            b.last = (k == n - 1);
            b.keep = (b.last && rem != 0) ? 16'((32'd1 << rem) - 32'd1) : 16'hFFFF;
            exp_beats.push_back(b);
        end
        @(posedge aclk);
        #1;
        cmd_addr  = addr;
        cmd_bytes = bytes;
        cmd_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge aclk);
            seen = cmd_ready;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL cmd_accept: got cmd_ready=0 for 50 cycles, need 1");
        end
        @(posedge aclk);
        #1;
        cmd_valid = 1'b0;
        hs_cycle  = cyc;
        arm_first = 1;
    endtask

    task automatic wait_done(input int start, input bit rand_ready);
        for (int i = 0; i < 3000 && done_cnt == start; i++) begin
            @(posedge aclk);
            #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
        m_axis_tready = 1'b1;
        check_eq("done_pulse", 128'(done_cnt), 128'(start + 1));
        repeat (3) @(posedge aclk);
        #1 check_eq("done_single", 128'(done_cnt), 128'(start + 1));
        check_eq("leftover_beats", 128'(exp_beats.size()), 128'(0));
        check_eq("leftover_reads", 128'(exp_addrs.size()), 128'(0));
    endtask

    initial begin
        int start;
        int base_seen;
        aresetn       = 1'b0;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_bytes     = '0;
        m_axis_tready = 1'b1;
        mem_rdata     = '0;

        repeat (2) @(posedge aclk);
        #1 reset_check();
        release_reset();

        // 64 bytes, full throughput
        start = done_cnt;
        send_cmd(32'h0000_0100, 32'd64);
        wait_done(start, 0);
        check_eq("first_tvalid_latency", 128'(first_tv_cycle - hs_cycle), 128'(2));
        check_eq("tlast_cycle", 128'(last_cycle - hs_cycle), 128'(5));

        // partial last beat
        start = done_cnt;
        send_cmd(32'h0000_0400, 32'd37);
        wait_done(start, 0);

        // zero-length command
        start = done_cnt;
        send_cmd(32'h0000_0800, 32'd0);
        wait_done(start, 0);
        @(negedge aclk);
        check_eq("zero_len_ready", 128'(cmd_ready), 128'(1));

        // 16 beats under random backpressure
        start = done_cnt;
        send_cmd(32'h0000_1000, 32'd256);
        wait_done(start, 1);

        // reset after beat 2 of 8
        base_seen = beats_seen;
        send_cmd(32'h0000_2000, 32'd128);
        for (int i = 0; i < 100 && beats_seen - base_seen < 2; i++) begin
            @(posedge aclk);
            #1;
        end
        check_eq("two_beats_before_reset", 128'(beats_seen - base_seen >= 2), 128'(1));
        aresetn = 1'b0;
        #1 reset_check();
        exp_beats.delete();
        exp_addrs.delete();
        reads_issued = 0;
        beats_seen   = 0;
        repeat (2) @(posedge aclk);
        release_reset();
        start = done_cnt;
        send_cmd(32'h0000_3000, 32'd48);
        wait_done(start, 0);

        // address wrap
        start = done_cnt;
        send_cmd(32'hFFFF_FFF0, 32'd32);
        wait_done(start, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_mm2s_feeder.md
AXIS_MM2S_FEEDER -- requirements
Module: axis_mm2s_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 128, output beat width in bits (multiple of 8, power of 2).
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width of command and memory port.
REQ-003 Parameter LEN_WIDTH, default 32, byte-count width of command.
REQ-004 Port aclk  input  1  sole clock, all logic on its rising edge.
REQ-005 Port aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 Port cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-007 Port cmd_addr  input  ADDR_WIDTH  start byte address, DATA_WIDTH/8-aligned; low log2(DATA_WIDTH/8) bits ignored.
REQ-008 Port cmd_bytes  input  LEN_WIDTH  transfer length in bytes.
REQ-009 Port mem_ren  output  1  memory read strobe.
REQ-010 Port mem_addr  output  ADDR_WIDTH  aligned byte address of the read.
REQ-011 Port mem_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after mem_ren.
REQ-012 Port m_axis_tvalid / m_axis_tready  output / input  1 / 1  stream handshake toward s_axis_pixels_* or s_axis_weights_* of the accelerator.
REQ-013 Port m_axis_tdata / m_axis_tkeep / m_axis_tlast  output  DATA_WIDTH / DATA_WIDTH/8 / 1  stream payload.
REQ-014 Port done  output  1  one-cycle pulse at transfer completion.

Function
REQ-015 FSM states: IDLE, READ, DRAIN.
REQ-016 IDLE: cmd_ready=1; on cmd_valid, latch address and beat count N=ceil(cmd_bytes/(DATA_WIDTH/8)); go to READ; when N=0, go to IDLE instead and pulse done the next cycle with no beats emitted.
REQ-017 READ: issue mem_ren with mem_addr incrementing by DATA_WIDTH/8 per read; after read N is issued, go to DRAIN.
REQ-018 A read is issued only when (reads in flight + buffered beats) < 2; no beat is ever dropped under backpressure.
REQ-019 Returned data enters a 2-entry FIFO; m_axis_tvalid = FIFO non-empty; pop on tvalid & tready.
REQ-020 With tready held 1, sustained throughput is 1 beat/cycle; first tvalid occurs 2 cycles after the cmd handshake.
REQ-021 tlast=1 only on beat N; tkeep all-ones except beat N, whose tkeep has its low (cmd_bytes mod DATA_WIDTH/8) bits set (all-ones if the remainder is 0).
REQ-022 Beat order is LSB-first: memory word k maps to beat k unchanged.
REQ-023 DRAIN: on handshake of the tlast beat, pulse done in the same cycle and return to IDLE; cmd_ready=0 in READ and DRAIN.
REQ-024 tvalid, once asserted, stays asserted with stable tdata/tkeep/tlast until the handshake completes (AXI-stream rule).
REQ-025 Address wrap at 2^ADDR_WIDTH wraps silently modulo 2^ADDR_WIDTH.
REQ-026 cmd_bytes = 2^LEN_WIDTH-1 is handled without counter overflow (beat counter LEN_WIDTH bits wide).

Reset
REQ-027 While aresetn=0: state=IDLE, FIFO empty, cmd_ready=0, mem_ren=0, mem_addr=0, m_axis_tvalid=0, tlast=0, tkeep=0, done=0.
REQ-028 cmd_ready first asserts one cycle after aresetn deasserts.
REQ-029 Reset mid-transfer abandons the transfer; any mem_rdata arriving after reset is discarded.

Structure
REQ-030 The shared params package holds the beat-byte constant and the FSM state encoding; no other shared typedefs.
REQ-031 The 2-entry FIFO is one sub-module, axis_fifo2 (DATA_WIDTH+DATA_WIDTH/8+1 bits, valid/ready both sides, no combinational tready-to-tready path).

Verification
REQ-032 addr=0x100, bytes=64, tready=1 -> 4 beats from words 0x100..0x130, tkeep=0xFFFF each, tlast on beat 4, done on that cycle.
REQ-033 bytes=37 -> 3 beats, beat 3 tkeep=0x001F with tlast=1.
REQ-034 bytes=0 -> no tvalid, single done pulse, cmd_ready back to 1.
REQ-035 bytes=256, tready toggled at random (50%) -> 16 beats in order, no loss or duplication, in-flight reads+buffered beats never exceed 2, payload stable while stalled.
REQ-036 aresetn pulsed low after beat 2 of 8 -> all outputs at reset values immediately; a new command then completes correctly.
REQ-037 addr=0xFFFFFFF0, bytes=32 -> mem_addr sequence 0xFFFFFFF0, 0x00000000.
